// File: rtl/frame_buffer_ctrl_if.sv
// rtl/frame_buffer_ctrl_if.sv - capture/display/control bus for frame_buffer_ctrl
//
// Purpose: groups the frame buffer's pixel write port, display read port and
// clear/swap control into one bundle.
// Signals:
//   wr_en, wr_addr[AW], wr_data[DW]  capture-side pixel write
//   rd_addr[AW] -> rd_data[DW]       display read, one cycle latency
//   rd_oob                           last read address was outside the image
//   clr_req -> busy                  fill the write bank with the background colour
//   frame_done -> bank_sel           display bank swap request / current display bank
// Modports: master drives requests (capture/display side), slave is the controller.
interface frame_buffer_ctrl_if #(
  parameter int AW = 15,
  parameter int DW = 12
);
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_data;
  logic          rd_oob;
  logic          clr_req;
  logic          busy;
  logic          frame_done;
  logic          bank_sel;

  modport master (
    output wr_en, wr_addr, wr_data, rd_addr, clr_req, frame_done,
    input  rd_data, rd_oob, busy, bank_sel
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, rd_addr, clr_req, frame_done,
    output rd_data, rd_oob, busy, bank_sel
  );
endinterface

// File: rtl/frame_buffer_ctrl.sv
// rtl/frame_buffer_ctrl.sv - single-clock frame buffer with background clear and optional double buffering
//
// Purpose: stores an IMG_W x IMG_H image of DW-bit pixels. The capture side
// writes pixels, the display side reads them with one cycle of latency, and a
// clear request fills the write bank with FILL_VAL at one pixel per cycle.
// Ports:
//   clk    single clock, all reads and writes on its rising edge
//   reset  asynchronous, active-high; memory contents are not reset
//   bus    frame_buffer_ctrl_if.slave (write port, read port, clr_req/busy,
//          frame_done/bank_sel)
// Configuration:
//   FRAME_BUFFER_CTRL_DOUBLE_BUF_EN  defined: two banks, display reads bank_sel,
//          writes and clears target the other bank, frame_done swaps them.
//          undefined: one bank shared by reads and writes, bank_sel is 0.
module frame_buffer_ctrl #(
  parameter int            AW       = 15,
  parameter int            DW       = 12,
  parameter int            IMG_W    = 160,
  parameter int            IMG_H    = 120,
  parameter logic [DW-1:0] FILL_VAL = 12'h000
) (
  input  logic                clk,
  input  logic                reset,
  frame_buffer_ctrl_if.slave  bus
);

  localparam int NPIX = IMG_W * IMG_H;
  // One extra bit so NPIX == 2**AW is still representable for range compares.
  localparam logic [AW:0]   NPIX_X    = (AW+1)'(NPIX);
  localparam logic [AW-1:0] LAST_ADDR = AW'(NPIX - 1);

  if (NPIX > 2**AW) begin : g_size_check
    $error("frame_buffer_ctrl: IMG_W*IMG_H does not fit in 2**AW words");
  end

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t        state;
  logic [AW-1:0] clr_cnt;
  logic          busy_q;
  logic [DW-1:0] rd_data_q;
  logic          rd_oob_q;

  logic          wr_ok;
  logic          clr_we;
  logic          mem_we;
  logic [AW-1:0] mem_waddr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          rd_in_range;

  // Capture writes are only honoured while idle; during a clear the clear
  // owns the write port and capture writes are dropped.
  assign wr_ok       = (state == IDLE) && bus.wr_en && ({1'b0, bus.wr_addr} < NPIX_X);
  assign clr_we      = (state == CLEAR);
  assign mem_we      = wr_ok | clr_we;
  assign mem_waddr   = clr_we ? clr_cnt  : bus.wr_addr;
  assign mem_wdata   = clr_we ? FILL_VAL : bus.wr_data;
  assign rd_in_range = {1'b0, bus.rd_addr} < NPIX_X;

`ifdef FRAME_BUFFER_CTRL_DOUBLE_BUF_EN
  logic          bank_sel_q;
  logic          swap_pending;
  logic [DW-1:0] mem [2][2**AW];

  always_ff @(posedge clk) begin
    if (mem_we) mem[~bank_sel_q][mem_waddr] <= mem_wdata;
  end
  // Combinational fetch sampled by the output register gives read-first
  // behaviour on a same-address write.
  assign mem_rdata    = mem[bank_sel_q][bus.rd_addr];
  assign bus.bank_sel = bank_sel_q;
`else
  logic [DW-1:0] mem [2**AW];
  logic          unused_frame_done;

  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
  end
  assign mem_rdata         = mem[bus.rd_addr];
  assign bus.bank_sel      = 1'b0;
  assign unused_frame_done = bus.frame_done;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      clr_cnt   <= '0;
      busy_q    <= 1'b0;
      rd_data_q <= '0;
      rd_oob_q  <= 1'b0;
`ifdef FRAME_BUFFER_CTRL_DOUBLE_BUF_EN
      bank_sel_q   <= 1'b0;
      swap_pending <= 1'b0;
`endif
    end else begin
      rd_oob_q  <= ~rd_in_range;
      rd_data_q <= rd_in_range ? mem_rdata : FILL_VAL;

      case (state)
        IDLE: begin
          if (bus.clr_req) begin
            state   <= CLEAR;
            busy_q  <= 1'b1;
            clr_cnt <= '0;
          end
        end
        CLEAR: begin
          // clr_req is ignored here; a request during a clear is not queued.
          clr_cnt <= clr_cnt + 1'b1;
          if (clr_cnt == LAST_ADDR) begin
            state   <= IDLE;
            busy_q  <= 1'b0;
            clr_cnt <= '0;
          end
        end
      endcase

`ifdef FRAME_BUFFER_CTRL_DOUBLE_BUF_EN
      // Swapping banks mid-clear would split the fill across both banks, so
      // a swap requested during a clear waits for the first idle cycle.
      // A clear accepted together with a swap naturally lands on the new
      // back bank because the write bank is derived from the updated bank_sel.
      if (state == IDLE) begin
        if (bus.frame_done || swap_pending) begin
          bank_sel_q   <= ~bank_sel_q;
          swap_pending <= 1'b0;
        end
      end else if (bus.frame_done) begin
        swap_pending <= 1'b1;
      end
`endif
    end
  end

  assign bus.busy    = busy_q;
  assign bus.rd_data = rd_data_q;
  assign bus.rd_oob  = rd_oob_q;

endmodule

// File: doc/frame_buffer_ctrl.md
FRAME_BUFFER_CTRL -- requirements
Module: frame_buffer_ctrl

Interface
REQ-001 Parameter AW, default 15: address width per bank.
REQ-002 Parameter DW, default 12: pixel width, RGB444.
REQ-003 Parameter IMG_W, default 160: image width in pixels.
REQ-004 Parameter IMG_H, default 120: image height in pixels.
REQ-005 Parameter FILL_VAL, default 12'h000: background/clear colour.
REQ-006 Derived constant NPIX = IMG_W*IMG_H; NPIX SHALL be <= 2**AW, enforced by an elaboration-time check.
REQ-007 Port clk, in, 1: the single clock for all logic. Reads and writes both use rising edges of clk.
REQ-008 Port reset, in, 1: asynchronous, active-high reset.
REQ-009 Port wr_en, in, 1: capture write strobe.
REQ-010 Port wr_addr, in, AW: capture pixel address.
REQ-011 Port wr_data, in, DW: capture pixel data.
REQ-012 Port rd_addr, in, AW: VGA read address.
REQ-013 Port rd_data, out, DW: registered VGA pixel.
REQ-014 Port rd_oob, out, 1: registered flag; the last read address was >= NPIX.
REQ-015 Port clr_req, in, 1: single-cycle request to fill the write bank with FILL_VAL.
REQ-016 Port busy, out, 1: high while a clear is in progress.
REQ-017 Port frame_done, in, 1: single-cycle bank-swap request. It is used only with DOUBLE_BUF_EN.
REQ-018 Port bank_sel, out, 1: the bank currently being displayed.

Function
REQ-019 A write SHALL occur when all of these hold at the rising edge: wr_en=1, wr_addr<NPIX, and state IDLE. Otherwise the write SHALL be dropped silently.
REQ-020 Read latency SHALL be 1 cycle.
 - rd_data = mem[rd_addr] when rd_addr<NPIX.
 - rd_data = FILL_VAL and rd_oob=1 when rd_addr>=NPIX.
REQ-021 Same-address read and write in one cycle SHALL be read-first: rd_data returns the old content.
REQ-022 The FSM SHALL have exactly two states, IDLE and CLEAR.
 - IDLE -> CLEAR when clr_req=1.
 - CLEAR -> IDLE after the write to address NPIX-1.
REQ-023 In CLEAR, an internal AW-bit counter SHALL start at 0 and write FILL_VAL to one address per cycle. The clear SHALL take exactly NPIX cycles; busy=1 for exactly those cycles.
REQ-024 clr_req asserted during CLEAR SHALL be ignored, with no queuing. wr_en asserted during CLEAR SHALL be dropped.
REQ-025 Reads SHALL continue unaffected during CLEAR.
REQ-026 busy SHALL be registered, rising the cycle after clr_req is sampled.

Reset
REQ-027 On reset assertion, without waiting for a clock edge, the block SHALL set: state=IDLE, counter=0, rd_data=0, rd_oob=0, busy=0, bank_sel=0, swap_pending=0.
REQ-028 Memory contents SHALL NOT be reset.
REQ-029 Reset during CLEAR SHALL abort the clear and leave memory partially filled. No further FILL_VAL writes SHALL occur after reset.

Configuration
REQ-030 Macro FRAME_BUFFER_CTRL_DOUBLE_BUF_EN defined: memory SHALL be 2 banks of 2**AW words.
 - Reads use bank bank_sel.
 - Writes and clears use bank ~bank_sel.
REQ-031 With the macro defined, frame_done in IDLE SHALL toggle bank_sel at the next edge.
 - frame_done during CLEAR SHALL set swap_pending. The toggle then happens on the first cycle after returning to IDLE, and swap_pending clears.
REQ-032 With the macro defined, if clr_req and frame_done are sampled together in IDLE, both SHALL be accepted. The clear SHALL then target the new back bank (the old front bank).
REQ-033 Macro undefined: one bank of 2**AW words, used for both reads and writes. frame_done SHALL be ignored and bank_sel tied to 0.

Verification
REQ-034 Write wr_addr=5, wr_data=12'hABC; next cycle set rd_addr=5 (macro off) -> rd_data=12'hABC one cycle later, rd_oob=0.
REQ-035 rd_addr=19200 (=NPIX) -> rd_data=12'h000 and rd_oob=1 one cycle later. wr_addr=19200 with wr_en=1 -> no memory change.
REQ-036 Pulse clr_req with wr_en=1 throughout -> busy high exactly 19200 cycles, every address reads 12'h000 afterwards, and all writes during busy are dropped.
REQ-037 Reset asserted at clear cycle 100 -> busy=0 immediately, addresses 0..99 read 12'h000, and address 100 keeps its prior value.
REQ-038 Macro on: write 12'h0F0 to address 0, pulse frame_done -> bank_sel=1 next cycle, and rd_addr=0 returns 12'h0F0.
REQ-039 Macro on: frame_done during CLEAR -> bank_sel unchanged until busy falls, then toggles one cycle later.
